// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP definitions used by the entry-read arbitration path.
package rv_iopmp_pkg;

  localparam int unsigned ENTRY_WIDTH_DEFAULT = 128;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rv_iopmp_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module rv_iopmp_rr_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] idx,
  output logic            any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        idx = IdxW'((int'(ptr) + i) % N);
      end
    end
    gnt = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/rv_iopmp_entry_rd_arbiter.sv
// Shares the entry SRAM read port among TL matching instances,
// with bounded locking and a tag pipe routing data back.
module rv_iopmp_entry_rd_arbiter
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUMBER_TL_INSTANCES = 4,
  parameter int unsigned NUMBER_ENTRIES      = 8,
  parameter int unsigned ENTRY_WIDTH         = ENTRY_WIDTH_DEFAULT,
  parameter int unsigned SRAM_LATENCY        = 1,
  parameter int unsigned MAX_HOLD            = 4,
  localparam int unsigned N    = NUMBER_TL_INSTANCES,
  localparam int unsigned AW   = idx_w(NUMBER_ENTRIES),
  localparam int unsigned IdxW = idx_w(N),
  localparam int unsigned HW   = $clog2(MAX_HOLD + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  stall_i,
  input  logic [N-1:0]          req_i,
  input  logic [N-1:0]          lock_i,
  input  logic [N-1:0][AW-1:0]  addr_i,
  output logic [N-1:0]          gnt_o,
  output logic [N-1:0]          rvalid_o,
  output logic [ENTRY_WIDTH-1:0] rdata_o,
  output logic                  sram_req_o,
  output logic [AW-1:0]         sram_addr_o,
  input  logic [ENTRY_WIDTH-1:0] sram_rdata_i
);

  typedef struct packed {
    logic            valid;
    logic [IdxW-1:0] idx;
  } entry_rd_tag_t;

  logic [IdxW-1:0] rr_ptr;
  logic [IdxW-1:0] owner;
  logic            owner_valid;
  logic [HW-1:0]   hold_cnt;

  logic [N-1:0]    arb_gnt;
  logic [IdxW-1:0] arb_idx;
  logic            arb_any;

  logic            others_req;
  logic            own_sel;
  logic [IdxW-1:0] gnt_idx;
  logic [IdxW-1:0] next_ptr;
  logic            same_owner;
  logic [HW-1:0]   hold_inc;

  entry_rd_tag_t   pipe [SRAM_LATENCY];

  rv_iopmp_rr_arbiter #(
    .N(N)
  ) u_rr (
    .req(req_i),
    .ptr(rr_ptr),
    .gnt(arb_gnt),
    .idx(arb_idx),
    .any(arb_any)
  );

  // The owner keeps the port past MAX_HOLD only when nobody else waits.
  assign others_req = |(req_i & ~(N'(1) << owner));
  assign own_sel    = owner_valid && req_i[owner] &&
                      ((hold_cnt < HW'(MAX_HOLD)) || !others_req);

  always_comb begin
    gnt_o   = '0;
    gnt_idx = arb_idx;
    if (!stall_i && arb_any) begin
      if (own_sel) begin
        gnt_idx = owner;
        gnt_o   = N'(1) << owner;
      end else begin
        gnt_o   = arb_gnt;
      end
    end
  end

  assign sram_req_o  = |gnt_o;
  assign sram_addr_o = addr_i[gnt_idx];

  assign next_ptr   = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + IdxW'(1);
  assign same_owner = owner_valid && (owner == gnt_idx);
  assign hold_inc   = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt
                                                  : hold_cnt + HW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr      <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      hold_cnt    <= '0;
    end else if (sram_req_o) begin
      rr_ptr <= next_ptr;
      if (lock_i[gnt_idx]) begin
        owner       <= gnt_idx;
        owner_valid <= 1'b1;
        hold_cnt    <= same_owner ? hold_inc : HW'(1);
      end else begin
        owner_valid <= 1'b0;
        hold_cnt    <= '0;
      end
    end else if (!stall_i && owner_valid && !req_i[owner]) begin
      owner_valid <= 1'b0;
      hold_cnt    <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SRAM_LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: sram_req_o, idx: gnt_idx};
      for (int i = 1; i < SRAM_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    if (pipe[SRAM_LATENCY-1].valid) begin
      rvalid_o[pipe[SRAM_LATENCY-1].idx] = 1'b1;
    end
  end

  assign rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_rv_iopmp_entry_rd_arbiter.sv
// Directed bench for the entry read arbiter at latency 1 and 3.
module tb_rv_iopmp_entry_rd_arbiter;

  localparam int N  = 4;
  localparam int EW = 128;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0][AW-1:0] addr;

  logic [N-1:0]  gnt, rvalid, gnt3, rvalid3;
  logic [EW-1:0] rdata, rdata3, srd, srd3;
  logic          sreq, sreq3;
  logic [AW-1:0] saddr, saddr3;
  logic [AW-1:0] ad1;
  logic [AW-1:0] ad3 [3];

  int total = 0;
  int bad = 0;

  logic [3:0] exp, prev;
  logic [3:0] seq [5];

  always #5 clk = ~clk;

  function automatic logic [EW-1:0] ent(input logic [AW-1:0] a);
    return {4{32'hCAFE_0000 + 32'(a)}};
  endfunction

  always @(posedge clk) begin
    ad1    <= saddr;
    ad3[0] <= saddr3;
    ad3[1] <= ad3[0];
    ad3[2] <= ad3[1];
  end

  assign srd  = ent(ad1);
  assign srd3 = ent(ad3[2]);

  rv_iopmp_entry_rd_arbiter #(
    .NUMBER_TL_INSTANCES(N),
    .NUMBER_ENTRIES(8),
    .ENTRY_WIDTH(EW),
    .SRAM_LATENCY(1),
    .MAX_HOLD(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .stall_i(stall),
    .req_i(req),
    .lock_i(lock),
    .addr_i(addr),
    .gnt_o(gnt),
    .rvalid_o(rvalid),
    .rdata_o(rdata),
    .sram_req_o(sreq),
    .sram_addr_o(saddr),
    .sram_rdata_i(srd)
  );

  rv_iopmp_entry_rd_arbiter #(
    .NUMBER_TL_INSTANCES(N),
    .NUMBER_ENTRIES(8),
    .ENTRY_WIDTH(EW),
    .SRAM_LATENCY(3),
    .MAX_HOLD(4)
  ) dut3 (
    .clk_i(clk),
    .rst_ni(rst_n),
    .stall_i(stall),
    .req_i(req),
    .lock_i(lock),
    .addr_i(addr),
    .gnt_o(gnt3),
    .rvalid_o(rvalid3),
    .rdata_o(rdata3),
    .sram_req_o(sreq3),
    .sram_addr_o(saddr3),
    .sram_rdata_i(srd3)
  );

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic s, input logic [3:0] r,
                     input logic [3:0] l);
    @(negedge clk);
    stall = s;
    req   = r;
    lock  = l;
    #1;
  endtask

  initial begin
    addr = {3'd7, 3'd6, 3'd1, 3'd3};

    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 128'(gnt), 128'(0));
    check("rst_rvalid", 128'(rvalid), 128'(0));
    check("rst_sreq", 128'(sreq), 128'(0));
    check("rst_rvalid3", 128'(rvalid3), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single read of instance 0 (entry 3)
    cyc(0, 4'b0001, 4'b0000);
    check("single_gnt", 128'(gnt), 128'(4'b0001));
    check("single_sreq", 128'(sreq), 128'(1));
    check("single_addr", 128'(saddr), 128'(3));
    cyc(0, 4'b0000, 4'b0000);
    check("single_rvalid", 128'(rvalid), 128'(4'b0001));
    check("single_rdata", rdata, ent(3'd3));
    check("single_idle", 128'(gnt), 128'(0));

    // round robin, pointer starts at 1 after the single read
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      cyc(0, 4'b1111, 4'b0000);
      exp = 4'(1) << ((1 + k) % 4);
      check($sformatf("rr_gnt%0d", k), 128'(gnt), 128'(exp));
      if (k > 0) begin
        check($sformatf("rr_rv%0d", k), 128'(rvalid), 128'(prev));
        check($sformatf("rr_rd%0d", k), rdata, ent(addr[k % 4]));
      end
      prev = exp;
    end
    cyc(0, 4'b0000, 4'b0000);
    check("rr_rv_last", 128'(rvalid), 128'(prev));

    // lock bound: instance 1 locks while instance 2 waits
    seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    for (int k = 0; k < 5; k++) begin
      cyc(0, 4'b0110, 4'b0010);
      check($sformatf("lock_gnt%0d", k), 128'(gnt), 128'(seq[k]));
    end
    for (int k = 0; k < 6; k++) begin
      cyc(0, 4'b0010, 4'b0010);
      check($sformatf("lock_solo%0d", k), 128'(gnt), 128'(4'b0010));
    end

    // stall keeps owner and hold count
    cyc(0, 4'b0000, 4'b0000);
    check("rel_gnt", 128'(gnt), 128'(0));
    cyc(0, 4'b0010, 4'b0010);
    check("st_pre0", 128'(gnt), 128'(4'b0010));
    cyc(0, 4'b1111, 4'b0010);
    check("st_pre1", 128'(gnt), 128'(4'b0010));
    for (int k = 0; k < 3; k++) begin
      cyc(1, 4'b1111, 4'b0010);
      check($sformatf("st_gnt%0d", k), 128'(gnt), 128'(0));
      check($sformatf("st_sreq%0d", k), 128'(sreq), 128'(0));
      if (k == 0) check("st_inflight", 128'(rvalid), 128'(4'b0010));
    end
    seq = '{4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000};
    for (int k = 0; k < 3; k++) begin
      cyc(0, 4'b1111, 4'b0010);
      check($sformatf("st_post%0d", k), 128'(gnt), 128'(seq[k]));
    end
    cyc(0, 4'b0000, 4'b0000);
    check("st_rv_last", 128'(rvalid), 128'(4'b0100));
    repeat (3) cyc(0, 4'b0000, 4'b0000);

    // latency 3: grants to 0, 2, 3 back to back
    cyc(0, 4'b0001, 4'b0000);
    check("l3_gnt0", 128'(gnt3), 128'(4'b0001));
    check("l3_rv0", 128'(rvalid3), 128'(0));
    cyc(0, 4'b0100, 4'b0000);
    check("l3_gnt1", 128'(gnt3), 128'(4'b0100));
    check("l3_rv1", 128'(rvalid3), 128'(0));
    cyc(0, 4'b1000, 4'b0000);
    check("l3_gnt2", 128'(gnt3), 128'(4'b1000));
    check("l3_rv2", 128'(rvalid3), 128'(0));
    cyc(0, 4'b0000, 4'b0000);
    check("l3_rv3", 128'(rvalid3), 128'(4'b0001));
    check("l3_rd3", rdata3, ent(3'd3));
    cyc(0, 4'b0000, 4'b0000);
    check("l3_rv4", 128'(rvalid3), 128'(4'b0100));
    check("l3_rd4", rdata3, ent(3'd6));
    cyc(0, 4'b0000, 4'b0000);
    check("l3_rv5", 128'(rvalid3), 128'(4'b1000));
    check("l3_rd5", rdata3, ent(3'd7));

    // reset with reads in flight
    cyc(0, 4'b0010, 4'b0000);
    check("mr_gnt0", 128'(gnt), 128'(4'b0010));
    cyc(0, 4'b0100, 4'b0000);
    check("mr_gnt1", 128'(gnt), 128'(4'b0100));
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("mr_rv", 128'(rvalid), 128'(0));
    check("mr_rv3", 128'(rvalid3), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b1111;
    #1;
    check("mr_first", 128'(gnt), 128'(4'b0001));
    check("mr_rv_a", 128'(rvalid), 128'(0));
    check("mr_rv3_a", 128'(rvalid3), 128'(0));
    cyc(0, 4'b0000, 4'b0000);
    check("mr_rv_b", 128'(rvalid), 128'(4'b0001));
    check("mr_rv3_b", 128'(rvalid3), 128'(0));
    cyc(0, 4'b0000, 4'b0000);
    check("mr_rv3_c", 128'(rvalid3), 128'(0));
    cyc(0, 4'b0000, 4'b0000);
    check("mr_rv3_d", 128'(rvalid3), 128'(4'b0001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
